// File: rtl/debug_frame_sequencer_pkg.sv
// Shared types and constants for the debug frame sequencer.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    LOAD,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0]  HEADER     = 8'hA5;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam int          NREGS      = 32;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_HALT = 8'h68;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  localparam logic [7:0] FRAME_LEN = 8'd142;
  localparam logic [7:0] IDX_PC    = 8'd129;
  localparam logic [7:0] IDX_INSTR = 8'd133;
  localparam logic [7:0] IDX_CTRL  = 8'd137;
  localparam logic [7:0] IDX_CSUM  = 8'd141;

  // Lane 3 is the most significant byte, so words go out MSB first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd3:    b = word[31:24];
      2'd2:    b = word[23:16];
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_frame_sequencer_if.sv
// Host-side command strobe and UART transmit handshake.
interface debug_frame_sequencer_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;

  modport master (
    input  cmd_valid, cmd_byte, tx_done_tick,
    output tx_start, tx_data
  );

  modport slave (
    output cmd_valid, cmd_byte, tx_done_tick,
    input  tx_start, tx_data
  );
endinterface

// File: rtl/debug_frame_sequencer_byte_mux.sv
// Selects the frame byte for a given byte index and drives the register-file read address.
module debug_byte_mux
  import debug_pkg::*;
(
  input  logic [7:0]  byte_idx,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] ctrl_in,
  input  logic [7:0]  checksum,
  output logic [7:0]  tx_byte,
  output logic [4:0]  reg_addr
);

  // Offset from the first payload byte; every payload word starts on a multiple of 4.
  logic [6:0] rel;
  logic [1:0] lane;

  assign rel  = 7'(byte_idx - 8'd1);
  assign lane = 2'd3 - rel[1:0];

  // Frame layout decode.
  always_comb begin
    tx_byte  = 8'h00;
    reg_addr = 5'd0;
    if (byte_idx == 8'd0) begin
      tx_byte = HEADER;
    end else if (byte_idx < IDX_PC) begin
      reg_addr = rel[6:2];
      tx_byte  = word_byte(reg_data, lane);
    end else if (byte_idx < IDX_INSTR) begin
      tx_byte = word_byte(pc_in, lane);
    end else if (byte_idx < IDX_CTRL) begin
      tx_byte = word_byte(instr_in, lane);
    end else if (byte_idx < IDX_CSUM) begin
      tx_byte = word_byte(ctrl_in, lane);
    end else if (byte_idx == IDX_CSUM) begin
      tx_byte = checksum;
    end
  end

endmodule

// File: rtl/debug_frame_sequencer.sv
// Debug controller: decodes host commands, gates the CPU, and streams a state dump frame.
//
//   state | meaning
//   IDLE  | CPU stopped, waiting for a command
//   RUN   | CPU free-running until halt command or halt instruction
//   STEP  | CPU enabled for exactly one cycle
//   LOAD  | present byte_idx on tx_data; first visit after IDLE/RUN only arms tx_start
//   WAIT  | hold tx_data until the transmitter acknowledges
//   DONE  | one-cycle frame_done, counters cleared
module debug_frame_sequencer
  import debug_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  debug_frame_sequencer_if.master        host,
  output logic [4:0]                     reg_addr,
  input  logic [31:0]                    reg_data,
  input  logic [31:0]                    pc_in,
  input  logic [31:0]                    instr_in,
  input  logic [31:0]                    ctrl_in,
  output logic                           cpu_enable,
  output logic                           busy,
  output logic                           frame_done
);

  state_t     state, state_next;
  logic [7:0] byte_idx;
  logic [7:0] checksum;
  logic [7:0] mux_byte;
  logic       load_armed;
  logic       tx_start_c;

  debug_byte_mux u_byte_mux (
    .byte_idx (byte_idx),
    .reg_data (reg_data),
    .pc_in    (pc_in),
    .instr_in (instr_in),
    .ctrl_in  (ctrl_in),
    .checksum (checksum),
    .tx_byte  (mux_byte),
    .reg_addr (reg_addr)
  );

  assign host.tx_start = tx_start_c;
  assign host.tx_data  = (state == LOAD || state == WAIT) ? mux_byte : 8'h00;

  // State, byte counter and running checksum. load_armed gives a one-cycle settle in LOAD
  // when the dump is entered straight from IDLE or RUN, matching the STEP path latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= 8'd0;
      checksum   <= 8'd0;
      load_armed <= 1'b0;
    end else begin
      state      <= state_next;
      load_armed <= (state == STEP) || (state == LOAD) || (state == WAIT);
      if (state == WAIT && host.tx_done_tick) begin
        if (byte_idx != 8'd0 && byte_idx < IDX_CSUM)
          checksum <= checksum ^ mux_byte;
        byte_idx <= byte_idx + 8'd1;
      end else if (state == DONE) begin
        byte_idx <= 8'd0;
        checksum <= 8'd0;
      end
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_next = state;
    cpu_enable = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    tx_start_c = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (host.cmd_valid) begin
          case (host.cmd_byte)
            CMD_RUN:            state_next = RUN;
            CMD_STEP:           state_next = STEP;
            CMD_DUMP, CMD_HALT: state_next = LOAD;
            default:            state_next = IDLE;
          endcase
        end
      end
      RUN: begin
        busy       = 1'b0;
        cpu_enable = 1'b1;
        if ((host.cmd_valid && host.cmd_byte == CMD_HALT) || instr_in == HALT_INSTR)
          state_next = LOAD;
      end
      STEP: begin
        cpu_enable = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        if (load_armed) begin
          tx_start_c = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (host.tx_done_tick)
          state_next = (byte_idx == IDX_CSUM) ? DONE : LOAD;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_frame_sequencer.sv
// Directed bench for debug_frame_sequencer.
module tb_debug_frame_sequencer;
  import debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic [31:0] ctrl_in;
  logic        cpu_enable;
  logic        busy;
  logic        frame_done;
  logic [31:0] regs [32];

  int checks   = 0;
  int failures = 0;

  int   cpu_en_cnt = 0;
  int   done_cnt   = 0;
  int   dbl_cnt    = 0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  debug_frame_sequencer_if bus ();

  assign reg_data = regs[reg_addr];

  debug_frame_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .host       (bus),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .pc_in      (pc_in),
    .instr_in   (instr_in),
    .ctrl_in    (ctrl_in),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (cpu_enable) cpu_en_cnt++;
    if (frame_done) done_cnt++;
    if (bus.tx_start && prev_start) dbl_cnt++;
    prev_start = bus.tx_start;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    int lane;
    if (i == 0) return 8'hA5;
    if (i <= 128)      w = regs[(i - 1) / 4];
    else if (i <= 132) w = pc_in;
    else if (i <= 136) w = instr_in;
    else               w = ctrl_in;
    lane = 3 - ((i - 1) % 4);
    return w[lane*8 +: 8];
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    for (int i = 1; i <= 140; i++) c ^= exp_byte(i);
    return c;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Called at the negedge where byte 0's tx_start is visible.
  task automatic run_frame(input logic [7:0] csum, input int abort_at, input int inject_at);
    bit         hold_ok = 1'b1;
    bit         cpu_ok  = 1'b1;
    int         k;
    logic [7:0] exp;
    for (int i = 0; i < 142; i++) begin
      if (i > 0) begin
        k = 0;
        while (!bus.tx_start && k < 20) begin
          @(negedge clk);
          k++;
        end
        if (!bus.tx_start) begin
          chk("tx_start_timeout", {31'd0, bus.tx_start}, 32'd1);
          return;
        end
      end
      exp = (i == 141) ? csum : exp_byte(i);
      chk($sformatf("byte%0d", i), {24'd0, bus.tx_data}, {24'd0, exp});
      if (i == abort_at) return;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        if (bus.tx_data !== exp || bus.tx_start) hold_ok = 1'b0;
        if (cpu_enable) cpu_ok = 1'b0;
        if (i == inject_at && c == 2) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_byte  = CMD_STEP;
        end
        if (i == inject_at && c == 3) bus.cmd_valid = 1'b0;
      end
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
    end
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    chk("tx_hold", {31'd0, hold_ok}, 32'd1);
    chk("cpu_off_in_dump", {31'd0, cpu_ok}, 32'd1);
    @(negedge clk);
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    chk("idle_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
    chk({tag, "_cpu_enable"}, {31'd0, cpu_enable}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_reg_addr"}, {27'd0, reg_addr}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int en0;
    int d0;
    for (int k = 0; k < 32; k++) regs[k] = k;
    pc_in            = 32'h0000_0040;
    instr_in         = 32'h2002_0005;
    ctrl_in          = 32'h0000_01A3;
    bus.cmd_valid    = 1'b0;
    bus.cmd_byte     = 8'h00;
    bus.tx_done_tick = 1'b0;
    reset            = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Plain dump from IDLE; checksum hand-computed as 40^27^A2 = C5.
    d0 = done_cnt;
    send_cmd(CMD_DUMP);
    chk("dump_n1_start", {31'd0, bus.tx_start}, 32'd0);
    chk("dump_n1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("dump_n2_start", {31'd0, bus.tx_start}, 32'd1);
    run_frame(8'hC5, -1, -1);
    chk("dump_done_count", done_cnt - d0, 32'd1);

    // Single step with a different PC.
    pc_in = 32'hDEAD_BEEF;
    en0   = cpu_en_cnt;
    send_cmd(CMD_STEP);
    chk("step_n1_en", {31'd0, cpu_enable}, 32'd1);
    chk("step_n1_start", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("step_n2_en", {31'd0, cpu_enable}, 32'd0);
    chk("step_n2_start", {31'd0, bus.tx_start}, 32'd1);
    run_frame(model_csum(), -1, -1);
    chk("step_en_cycles", cpu_en_cnt - en0, 32'd1);
    pc_in = 32'h0000_0040;

    // Run stopped by the halt instruction.
    send_cmd(CMD_RUN);
    chk("run_en", {31'd0, cpu_enable}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    instr_in = 32'hFFFF_FFFF;
    chk("halti_m_en", {31'd0, cpu_enable}, 32'd1);
    tick();
    chk("halti_m1_en", {31'd0, cpu_enable}, 32'd0);
    chk("halti_m1_start", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("halti_m2_start", {31'd0, bus.tx_start}, 32'd1);
    run_frame(model_csum(), -1, -1);
    instr_in = 32'h2002_0005;

    // Run stopped by the halt command; a step command during the dump is dropped.
    send_cmd(CMD_RUN);
    repeat (2) tick();
    send_cmd(CMD_HALT);
    chk("haltc_m1_en", {31'd0, cpu_enable}, 32'd0);
    tick();
    chk("haltc_m2_start", {31'd0, bus.tx_start}, 32'd1);
    en0 = cpu_en_cnt;
    run_frame(model_csum(), -1, 10);
    chk("step_in_dump_ignored", cpu_en_cnt - en0, 32'd0);

    // Reset while waiting on byte 60, then a clean restart.
    d0 = done_cnt;
    send_cmd(CMD_DUMP);
    tick();
    run_frame(8'hC5, 60, -1);
    repeat (3) tick();
    chk("mid_reg_addr_nonzero", {31'd0, reg_addr != 5'd0}, 32'd1);
    reset = 1'b1;
    tick();
    check_all_zero("abort");
    reset = 1'b0;
    tick();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    send_cmd(CMD_DUMP);
    tick();
    chk("restart_start", {31'd0, bus.tx_start}, 32'd1);
    run_frame(8'hC5, -1, -1);

    // Spurious ack and unknown command in IDLE.
    bus.tx_done_tick = 1'b1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_byte     = 8'h41;
    tick();
    bus.tx_done_tick = 1'b0;
    bus.cmd_valid    = 1'b0;
    tick();
    check_all_zero("spurious");
    send_cmd(CMD_DUMP);
    tick();
    chk("post_spurious_start", {31'd0, bus.tx_start}, 32'd1);
    run_frame(8'hC5, -1, -1);

    chk("no_back_to_back_start", dbl_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
